// File: rtl/gsm_arb_pkg.sv
// gsm_arb_pkg
// Shared definitions for the output arbiter: FSM state encoding and the
// default sizing constants used as parameter defaults by gsm_out_arb.
package gsm_arb_pkg;

    localparam int GSM_NUM_PORT     = 4;
    localparam int GSM_LOG_NUM_PORT = 2;
    localparam int GSM_DATA_W       = 32;
    localparam int GSM_WDOG_CYCLES  = 255;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gsm_rr_pick.sv
// gsm_rr_pick
// Purely combinational rotating-priority encoder.
// Ports:
//   eligible  in   NUM_PORT      request vector
//   rr_ptr    in   LOG_NUM_PORT  highest-priority index this round
//   winner    out  LOG_NUM_PORT  first set bit at or above rr_ptr, wrapping
//   any_valid out  1             eligible is non-zero
module gsm_rr_pick #(
    parameter int NUM_PORT     = 4,
    parameter int LOG_NUM_PORT = 2
) (
    input  logic [NUM_PORT-1:0]     eligible,
    input  logic [LOG_NUM_PORT-1:0] rr_ptr,
    output logic [LOG_NUM_PORT-1:0] winner,
    output logic                    any_valid
);

    logic [LOG_NUM_PORT-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit to rr_ptr
    // is the last one written and therefore wins.
    always_comb begin
        winner    = '0;
        idx       = '0;
        any_valid = |eligible;
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
            idx = LOG_NUM_PORT'((int'(rr_ptr) + i) % NUM_PORT);
            if (eligible[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/gsm_out_arb.sv
// gsm_out_arb
// Packet-granular round-robin arbiter: NUM_PORT head-of-queue inputs share
// one output. A queue is locked from its sop beat until its eop beat is
// accepted; re-arbitration happens in IDLE, so one bubble follows each packet.
// Optional build macro GSM_OUT_ARB_WDOG_EN adds a stall watchdog that
// force-releases a lock after WDOG_CYCLES cycles without an accepted beat.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_sop/in_eop   per-queue head flags
//   in_data                  head beats, queue i at [i*DATA_W +: DATA_W]
//   in_ready                 per-queue pop strobe
//   out_valid/sop/eop/data   muxed beat of the locked queue
//   out_ready                downstream accept
//   out_src                  locked queue index
//   wdog_abort               one-cycle pulse on forced lock release
module gsm_out_arb
    import gsm_arb_pkg::*;
#(
    parameter int NUM_PORT     = GSM_NUM_PORT,
    parameter int LOG_NUM_PORT = GSM_LOG_NUM_PORT,
    parameter int DATA_W       = GSM_DATA_W,
    parameter int WDOG_CYCLES  = GSM_WDOG_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORT-1:0]        in_valid,
    input  logic [NUM_PORT-1:0]        in_sop,
    input  logic [NUM_PORT-1:0]        in_eop,
    input  logic [NUM_PORT*DATA_W-1:0] in_data,
    output logic [NUM_PORT-1:0]        in_ready,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [LOG_NUM_PORT-1:0]    out_src,
    output logic                       wdog_abort
);

    arb_state_e              state_q, state_d;
    logic [LOG_NUM_PORT-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_NUM_PORT-1:0] lock_idx_q, lock_idx_d;
    logic [LOG_NUM_PORT-1:0] winner;
    logic [LOG_NUM_PORT-1:0] next_ptr;
    logic                    any_valid;
    logic                    accept;
    logic [DATA_W-1:0]       beat_data [NUM_PORT];

`ifdef GSM_OUT_ARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_CYCLES != 0);
`endif

    for (genvar g = 0; g < NUM_PORT; g++) begin : g_split
        assign beat_data[g] = in_data[g*DATA_W +: DATA_W];
    end

    // Only heads that start a packet may win; mid-packet heads wait.
    gsm_rr_pick #(
        .NUM_PORT     (NUM_PORT),
        .LOG_NUM_PORT (LOG_NUM_PORT)
    ) u_pick (
        .eligible  (in_valid & in_sop),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign next_ptr = LOG_NUM_PORT'((int'(lock_idx_q) + 1) % NUM_PORT);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        out_valid  = 1'b0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;
        out_data   = '0;
        out_src    = '0;
        in_ready   = '0;
        wdog_abort = 1'b0;
        accept     = 1'b0;
`ifdef GSM_OUT_ARB_WDOG_EN
        wdog_cnt_d = wdog_cnt_q;
`endif
        // Outputs stay quiet during reset so a locked packet is abandoned
        // without a pop in the reset cycle.
        if (!rst) begin
            case (state_q)
                IDLE: begin
`ifdef GSM_OUT_ARB_WDOG_EN
                    wdog_cnt_d = '0;
`endif
                    if (any_valid) begin
                        state_d    = LOCK;
                        lock_idx_d = winner;
                    end
                end
                LOCK: begin
                    out_valid            = in_valid[lock_idx_q];
                    out_sop              = in_sop[lock_idx_q];
                    out_eop              = in_eop[lock_idx_q];
                    out_data             = beat_data[lock_idx_q];
                    out_src              = lock_idx_q;
                    in_ready[lock_idx_q] = out_ready & in_valid[lock_idx_q];
                    accept               = out_valid & out_ready;
                    if (accept && out_eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
`ifdef GSM_OUT_ARB_WDOG_EN
                    // Counter holds the number of completed stall cycles;
                    // the stall that would make it WDOG_CYCLES aborts.
                    if (accept) begin
                        wdog_cnt_d = '0;
                    end else if (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
                        wdog_abort = 1'b1;
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        wdog_cnt_d = '0;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
`ifdef GSM_OUT_ARB_WDOG_EN
            wdog_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
`ifdef GSM_OUT_ARB_WDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_gsm_out_arb.sv
// tb_gsm_out_arb
// Directed scenarios followed by randomized traffic. Each input queue is a
// list of beats; a cycle-level reference model derived from the arbitration
// rules predicts every output, and each comparison is an immediate assertion.
module tb_gsm_out_arb;

    localparam int N  = 4;
    localparam int LN = 2;
    localparam int DW = 32;
    localparam int WD = 8;
`ifdef GSM_OUT_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid, in_sop, in_eop, in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid, out_sop, out_eop, out_ready;
    logic [DW-1:0]     out_data;
    logic [LN-1:0]     out_src;
    logic              wdog_abort;

    always #5 clk = ~clk;

    gsm_out_arb #(
        .NUM_PORT     (N),
        .LOG_NUM_PORT (LN),
        .DATA_W       (DW),
        .WDOG_CYCLES  (WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .wdog_abort (wdog_abort)
    );

    typedef struct {
        bit          sop;
        bit          eop;
        logic [DW-1:0] data;
    } beat_t;

    beat_t bq [N][$];
    bit    hold [N];
    int    hold_cnt [N];
    int    n_chk = 0;
    int    n_fail = 0;

    // reference model: who owns the output, whose turn is next, stall count
    bit    m_lock;
    int    m_owner, m_ptr, m_stall, m_winner;
    bit    m_accept;
    logic  e_valid, e_sop, e_eop, e_abort;
    logic [DW-1:0] e_data;
    logic [LN-1:0] e_src;
    logic [N-1:0]  e_rdy;

    int    acc_src[$];
    bit    last_acc;
    int    b2b;
    int    abort_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int p, input int len, input int tag);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.sop  = (k == 0);
            b.eop  = (k == len - 1);
            b.data = {8'(p), 8'(tag), 16'(k)} ^ {16'h0, 16'($urandom) & 16'hF000};
            bq[p].push_back(b);
        end
    endtask

    // Invalid heads carry random flags/data to prove they are ignored.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0 && !hold[i]) begin
                in_valid[i]           = 1'b1;
                in_sop[i]             = bq[i][0].sop;
                in_eop[i]             = bq[i][0].eop;
                in_data[i*DW +: DW]   = bq[i][0].data;
            end else begin
                in_valid[i]           = 1'b0;
                in_sop[i]             = 1'($urandom);
                in_eop[i]             = 1'($urandom);
                in_data[i*DW +: DW]   = $urandom;
            end
        end
    endtask

    task automatic model_eval();
        int q;
        e_valid  = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_abort = 1'b0;
        e_data   = '0;   e_src = '0;   e_rdy = '0;
        m_accept = 1'b0; m_winner = -1;
        if (!rst) begin
            if (!m_lock) begin
                for (int k = 0; k < N; k++) begin
                    q = (m_ptr + k) % N;
                    if (m_winner < 0 && in_valid[q] && in_sop[q]) m_winner = q;
                end
            end else begin
                e_valid         = in_valid[m_owner];
                e_sop           = in_sop[m_owner];
                e_eop           = in_eop[m_owner];
                e_data          = in_data[m_owner*DW +: DW];
                e_src           = LN'(m_owner);
                e_rdy[m_owner]  = out_ready & in_valid[m_owner];
                m_accept        = e_valid && out_ready;
                e_abort         = WDOG_ON && !m_accept && (m_stall + 1 == WD);
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_lock = 0; m_ptr = 0; m_owner = 0; m_stall = 0;
        end else if (!m_lock) begin
            if (m_winner >= 0) begin
                m_lock = 1; m_owner = m_winner; m_stall = 0;
            end
        end else if (m_accept) begin
            m_stall = 0;
            if (e_eop) begin
                m_lock = 0; m_ptr = (m_owner + 1) % N;
            end
        end else if (e_abort) begin
            m_lock = 0; m_ptr = (m_owner + 1) % N; m_stall = 0;
        end else begin
            m_stall++;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] pops;
        bit acc;
        drive();
        #1;
        model_eval();
        chk("out_valid",  out_valid,  e_valid);
        chk("out_sop",    out_sop,    e_sop);
        chk("out_eop",    out_eop,    e_eop);
        chk("out_data",   out_data,   e_data);
        chk("out_src",    out_src,    e_src);
        chk("in_ready",   in_ready,   e_rdy);
        chk("wdog_abort", wdog_abort, e_abort);
        acc  = out_valid && out_ready;
        if (acc) acc_src.push_back(int'(out_src));
        if (acc && last_acc) b2b++;
        last_acc = acc;
        if (wdog_abort === 1'b1) abort_cnt++;
        pops = in_ready;
        @(posedge clk);
        model_update();
        for (int i = 0; i < N; i++)
            if (pops[i] === 1'b1 && bq[i].size() > 0) void'(bq[i].pop_front());
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int first_abort, stall_n, got;
        logic [DW-1:0] bp_data;

        rst = 1'b1; out_ready = 1'b1;
        m_lock = 0; m_ptr = 0; m_owner = 0; m_stall = 0;
        last_acc = 0; b2b = 0; abort_cnt = 0;
        for (int i = 0; i < N; i++) begin hold[i] = 0; hold_cnt[i] = 0; end
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;

        // reset state with traffic already presented
        push_pkt(2, 1, 1);
        repeat (2) cycle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  '0);
        rst = 1'b0;
        repeat (3) cycle();
        bq[2].delete();
        do_reset();

        // rotation: single-beat packets, grants 0,1,2,3,0 with bubbles
        push_pkt(0, 1, 2); push_pkt(0, 1, 3);
        push_pkt(1, 1, 2); push_pkt(2, 1, 2); push_pkt(3, 1, 2);
        acc_src.delete(); b2b = 0;
        repeat (12) cycle();
        chk("rot_count", acc_src.size(), 5);
        for (int k = 0; k < 5; k++) begin
            got = (k < acc_src.size()) ? acc_src[k] : -1;
            chk("rot_grant", got, k % N);
        end
        chk("rot_bubble", b2b, 0);

        // lock hold: q1 4-beat packet while q0/q2 wait; then q2 then q0
        push_pkt(1, 4, 4); push_pkt(0, 1, 4); push_pkt(2, 1, 4);
        acc_src.delete();
        repeat (14) cycle();
        chk("lock_count", acc_src.size(), 6);
        for (int k = 0; k < 6; k++) begin
            got = (k < acc_src.size()) ? acc_src[k] : -1;
            chk("lock_grant", got, (k < 4) ? 1 : ((k == 4) ? 2 : 0));
        end

        // backpressure mid-packet on q2
        push_pkt(2, 3, 5);
        bp_data = bq[2][1].data;
        repeat (2) cycle();
        out_ready = 1'b0;
        repeat (10) begin
            cycle();
            chk("bp_data", out_data, bp_data);
            chk("bp_rdy",  in_ready, '0);
            chk("bp_src",  out_src,  2'd2);
        end
        chk("bp_queue", bq[2].size(), 2);
        out_ready = 1'b1;
        repeat (4) cycle();

        // ineligible head: q3 mid-packet beat only
        push_pkt(3, 2, 6);
        void'(bq[3].pop_front());
        repeat (6) begin
            cycle();
            chk("inel_rdy3",  in_ready[3], 1'b0);
            chk("inel_valid", out_valid,   1'b0);
        end
        bq[3].delete();

        // watchdog: q0 goes silent after its sop beat
        do_reset();
        push_pkt(0, 2, 7);
        repeat (2) cycle();
        hold[0] = 1; abort_cnt = 0; first_abort = -1; stall_n = 0;
        repeat (20) begin
            cycle();
            stall_n++;
            if (wdog_abort === 1'b1 && first_abort < 0) first_abort = stall_n;
        end
        chk("wd_pulses", abort_cnt, WDOG_ON ? 1 : 0);
        chk("wd_when",   first_abort, WDOG_ON ? WD : -1);
        if (WDOG_ON) bq[0].delete();
        push_pkt(0, 1, 8); push_pkt(1, 1, 8);
        hold[0] = 0;
        acc_src.delete();
        repeat (8) cycle();
        got = (acc_src.size() > 0) ? acc_src[0] : -1;
        chk("wd_next", got, WDOG_ON ? 1 : 0);
        repeat (4) cycle();

        // reset during beat 2 of 3
        do_reset();
        push_pkt(1, 3, 9);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_nopop", bq[1].size(), 2);
        bq[1].delete();
        push_pkt(3, 1, 10); push_pkt(0, 1, 10);
        acc_src.delete();
        repeat (6) cycle();
        got = (acc_src.size() > 0) ? acc_src[0] : -1;
        chk("mrst_ptr", got, 0);

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() < 3 && $urandom_range(0, 3) == 0)
                    push_pkt(i, $urandom_range(1, 4), t);
                if (hold_cnt[i] == 0 && $urandom_range(0, 39) == 0)
                    hold_cnt[i] = $urandom_range(1, 12);
                else if (hold_cnt[i] > 0)
                    hold_cnt[i]--;
                hold[i] = (hold_cnt[i] > 0) || ($urandom_range(0, 9) == 0);
                // queues discard stranded mid-packet heads after aborts/resets
                if (bq[i].size() > 0 && !bq[i][0].sop && !(m_lock && m_owner == i)
                    && $urandom_range(0, 7) == 0)
                    void'(bq[i].pop_front());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gsm_out_arb.md
GSM_OUT_ARB -- requirements
Module: gsm_out_arb

Interface
REQ-001 Parameters SHALL be: NUM_PORT, default 4, the number of input queues sharing one output; LOG_NUM_PORT, default 2, log2(NUM_PORT); DATA_W, default 32, the beat width; WDOG_CYCLES, default 255, the stall limit in cycles.
REQ-002 clk  input  1  is the single clock for all state.
REQ-003 rst  input  1  is a synchronous, active-high reset.
REQ-004 in_valid  input  NUM_PORT  is the per-queue head-beat valid.
REQ-005 in_sop / in_eop  input  NUM_PORT each  are the per-queue start-of-packet and end-of-packet flags.
REQ-006 in_data  input  NUM_PORT*DATA_W  is the head beats; queue i occupies bits [i*DATA_W +: DATA_W].
REQ-007 in_ready  output  NUM_PORT  is the per-queue pop strobe.
REQ-008 out_valid, out_sop, out_eop  output  1 each, and out_data  output  DATA_W, are the muxed beat.
REQ-009 out_ready  input  1  is downstream accept.
REQ-010 out_src  output  LOG_NUM_PORT  is the index of the locked queue.
REQ-011 wdog_abort  output  1  is a one-cycle pulse when a packet lock is force-released.

Function
REQ-012 The block SHALL grant one output port to one input queue for a whole packet, using rotating-priority round robin.
REQ-013 FSM states SHALL be IDLE and LOCK.
REQ-014 In IDLE: eligible = in_valid & in_sop; if eligible != 0, the winner SHALL be the first set bit searching upward from rr_ptr, with wrap-around; the next state is LOCK; lock_idx <= winner.
REQ-015 In IDLE, heads with in_valid=1 and in_sop=0 SHALL NOT be eligible and SHALL NOT be popped.
REQ-016 In IDLE, out_valid SHALL be 0 and in_ready SHALL be all-zero.
REQ-017 Grant latency SHALL be 1 cycle: the first beat can transfer in the cycle after arbitration.
REQ-018 In LOCK, output signals SHALL be combinational from the locked queue: out_valid=in_valid[lock_idx]; out_sop, out_eop and out_data are taken from the same queue; out_src=lock_idx.
REQ-019 In LOCK, in_ready[lock_idx] SHALL be out_ready & in_valid[lock_idx]; all other in_ready bits SHALL be 0.
REQ-020 A beat SHALL be accepted when out_valid & out_ready.
REQ-021 An accepted beat with out_eop=1 SHALL cause: next state IDLE; rr_ptr <= lock_idx+1 modulo NUM_PORT.
REQ-022 One bubble cycle SHALL follow every packet, because re-arbitration occurs in IDLE.
REQ-023 A single-beat packet (sop=eop=1) SHALL occupy exactly one LOCK cycle when out_ready=1.
REQ-024 In LOCK, in_valid and out_ready changes on non-locked queues SHALL be ignored.
REQ-025 Backpressure: with out_ready=0, the lock SHALL hold and nothing SHALL be popped.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL set: state=IDLE, rr_ptr=0, lock_idx=0, watchdog counter=0.
REQ-027 While in reset, out_valid, in_ready, wdog_abort and out_src SHALL all be 0.
REQ-028 A reset during LOCK SHALL abandon the packet without a pop in that cycle; the queues are responsible for their own cleanup.

Configuration
REQ-029 Macro GSM_OUT_ARB_WDOG_EN SHALL control the watchdog.
REQ-030 When GSM_OUT_ARB_WDOG_EN is defined: in LOCK, a counter increments each cycle with no accepted beat and clears on every accepted beat.
REQ-031 When GSM_OUT_ARB_WDOG_EN is defined and the counter reaches WDOG_CYCLES: wdog_abort=1 for one cycle; next state IDLE; rr_ptr <= lock_idx+1; the counter clears.
REQ-032 When GSM_OUT_ARB_WDOG_EN is not defined: no counter is built; the lock holds indefinitely; wdog_abort is tied 0. The port list SHALL be identical in both builds.

Structure
REQ-033 Package gsm_arb_pkg SHALL hold the state enum (IDLE, LOCK) and the default constants for NUM_PORT, LOG_NUM_PORT, DATA_W and WDOG_CYCLES.
REQ-034 Sub-module gsm_rr_pick SHALL be a purely combinational rotating-priority encoder: inputs eligible vector and rr_ptr; outputs winner index and any_valid.
REQ-035 All state registers SHALL reside in gsm_out_arb.

Verification
REQ-036 Rotation: all four queues hold 1-beat packets, out_ready=1 → grants 0,1,2,3,0, each packet followed by a bubble.
REQ-037 Lock hold: queue 1 sends a 4-beat packet while queues 0/2 are valid with sop → out_src=1 for all 4 beats, then queue 2 is granted (rr_ptr=2).
REQ-038 Backpressure: out_ready=0 for 10 cycles mid-packet → out_data stable, in_ready=0, state remains LOCK.
REQ-039 Ineligible head: queue 3 valid with sop=0 and no others valid → state remains IDLE and in_ready[3] never asserts.
REQ-040 Watchdog (macro on, WDOG_CYCLES=8): queue 0 drops in_valid after sop → wdog_abort pulses once, 8 cycles after the last accepted beat; the next arbitration starts at queue 1. With the macro off, the same stimulus keeps LOCK.
REQ-041 Reset mid-packet: assert rst during beat 2 of 3 → next cycle shows IDLE, rr_ptr=0, out_valid=0.
